// File: rtl/tlb_pkg.sv
// -----------------------------------------------------------------------------
// tlb_pkg
// Shared constants, types and helpers for the TLB lookup front end.
//   - Geometry: ENTRIES, INDEX_W, VPN_W, OFFSET_W, VALUE_W
//   - Value-memory word layout: FRAME_HI/LO, WRITABLE_BIT, VALID_BIT
//   - Fault codes (tlb_fault_e), UNMAPPED_BASE, KEY_RESET
//   - tlb_fault():       fault priority resolution for one lookup
//   - unmapped_offset(): physical address of an address in the bypass window
// -----------------------------------------------------------------------------
package tlb_pkg;

  localparam int ENTRIES  = 32;
  localparam int INDEX_W  = 5;
  localparam int VPN_W    = 20;
  localparam int OFFSET_W = 12;
  localparam int VALUE_W  = 22;

  // Value memory word: {frame[19:0], writable, valid}
  localparam int FRAME_HI     = 21;
  localparam int FRAME_LO     = 2;
  localparam int WRITABLE_BIT = 1;
  localparam int VALID_BIT    = 0;

  localparam logic [31:0]      UNMAPPED_BASE = 32'hC000_0000;
  localparam logic [VPN_W-1:0] KEY_RESET     = 20'hF_FFFF;

  typedef enum logic [1:0] {
    FAULT_NONE    = 2'd0,
    FAULT_MISS    = 2'd1,
    FAULT_INVALID = 2'd2,
    FAULT_WPROT   = 2'd3
  } tlb_fault_e;

  // Miss outranks an invalid entry, which outranks a write-protect violation.
  function automatic tlb_fault_e tlb_fault(input logic hit, input logic valid,
                                           input logic writable, input logic is_write);
    tlb_fault_e code;
    if (!hit) begin
      code = FAULT_MISS;
    end else if (!valid) begin
      code = FAULT_INVALID;
    end else if (is_write && !writable) begin
      code = FAULT_WPROT;
    end else begin
      code = FAULT_NONE;
    end
    return code;
  endfunction

  function automatic logic [31:0] unmapped_offset(input logic [31:0] vaddr);
    return vaddr - UNMAPPED_BASE;
  endfunction

endpackage

// File: rtl/tlb_key_cam.sv
// -----------------------------------------------------------------------------
// tlb_key_cam
// Key store of the TLB: N virtual page numbers in flops, one write port and a
// fully parallel compare. The lowest matching slot wins.
// Ports:
//   clock, reset        clock and synchronous active-high reset (keys -> KEY_RESET)
//   i_wr_en/index/data  key write, takes effect at the rising edge
//   i_vpn               page number to look up (compared against current keys)
//   o_hit               at least one key matches
//   o_index             lowest matching slot, 0 when nothing matches
// -----------------------------------------------------------------------------
module tlb_key_cam
  import tlb_pkg::*;
#(
  parameter int N  = ENTRIES,
  parameter int IW = INDEX_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_wr_en,
  input  logic [IW-1:0]    i_wr_index,
  input  logic [VPN_W-1:0] i_wr_data,
  input  logic [VPN_W-1:0] i_vpn,
  output logic             o_hit,
  output logic [IW-1:0]    o_index
);

  logic [VPN_W-1:0] r_keys [N];
  logic [N-1:0]     w_match;
  logic             w_hit;
  logic [IW-1:0]    w_index;

  // Key storage: reset to all-ones, single write port.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        r_keys[i] <= KEY_RESET;
      end
    end else if (i_wr_en) begin
      r_keys[i_wr_index] <= i_wr_data;
    end
  end

  // Parallel compare of the incoming page number against every key.
  always_comb begin
    w_match = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      w_match[i] = (r_keys[i] == i_vpn);
    end
  end

  // Priority encoder: scanning from the top down lets the lowest slot overwrite last.
  always_comb begin
    w_hit   = 1'b0;
    w_index = {IW{1'b0}};
    for (int i = N - 1; i >= 0; i--) begin
      w_hit   = w_hit | w_match[i];
      w_index = w_match[i] ? IW'(i) : w_index;
    end
  end

  assign o_hit   = w_hit;
  assign o_index = w_index;

endmodule

// File: rtl/tlb_lookup.sv
// -----------------------------------------------------------------------------
// tlb_lookup
// Translation front end for the 32x22 TLB value memory. A request is matched
// against the key CAM in IDLE, the winning index reads the value memory
// (synchronous read), the value is checked in READ and the registered result
// is presented in RESP until the consumer takes it. One lookup in flight.
// Ports:
//   clock, reset                          clock, synchronous active-high reset
//   reqValid/reqReady/reqAddress/reqWrite request handshake and payload
//   respValid/respReady                   response handshake
//   respAddress/respFault/respIndex       physical address, fault code, entry index
//   valueIndex / valueData                value memory port 1 (index out, data in)
//   keyWriteEnable/Index/Data             software key update
// Build option:
//   TLB_LOOKUP_UNMAPPED_EN  addresses with [31:30]==2'b11 bypass translation,
//                           respAddress = reqAddress - UNMAPPED_BASE.
// -----------------------------------------------------------------------------
module tlb_lookup
  import tlb_pkg::*;
#(
  parameter int ENTRIES = tlb_pkg::ENTRIES,
  parameter int INDEX_W = tlb_pkg::INDEX_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               reqValid,
  output logic               reqReady,
  input  logic [31:0]        reqAddress,
  input  logic               reqWrite,
  output logic               respValid,
  input  logic               respReady,
  output logic [31:0]        respAddress,
  output logic [1:0]         respFault,
  output logic [INDEX_W-1:0] respIndex,
  output logic [INDEX_W-1:0] valueIndex,
  input  logic [VALUE_W-1:0] valueData,
  input  logic               keyWriteEnable,
  input  logic [INDEX_W-1:0] keyWriteIndex,
  input  logic [VPN_W-1:0]   keyWriteData
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_READ = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]          r_state;
  logic                r_req_ready;
  logic                r_resp_valid;
  logic [31:0]         r_resp_address;
  tlb_fault_e          r_resp_fault;
  logic [INDEX_W-1:0]  r_resp_index;
  logic [OFFSET_W-1:0] r_offset;
  logic                r_write;
  logic                r_hit;
  logic [INDEX_W-1:0]  r_index;
`ifdef TLB_LOOKUP_UNMAPPED_EN
  logic                r_unmapped;
  logic [VPN_W-1:0]    r_vpn;
`endif

  logic                w_cam_hit;
  logic [INDEX_W-1:0]  w_cam_index;
  logic [INDEX_W-1:0]  w_value_index;
  tlb_fault_e          w_fault;
  logic [31:0]         w_res_addr;
  logic [INDEX_W-1:0]  w_res_index;

  tlb_key_cam #(
    .N  (ENTRIES),
    .IW (INDEX_W)
  ) u_cam (
    .clock      (clock),
    .reset      (reset),
    .i_wr_en    (keyWriteEnable),
    .i_wr_index (keyWriteIndex),
    .i_wr_data  (keyWriteData),
    .i_vpn      (reqAddress[31:OFFSET_W]),
    .o_hit      (w_cam_hit),
    .o_index    (w_cam_index)
  );

  // Value memory index: live CAM result while idle so the read starts at the
  // acceptance edge; afterwards the latched index keeps the read stable.
  always_comb begin
    if (r_state == ST_IDLE) begin
      w_value_index = w_cam_index;
    end else begin
      w_value_index = r_index;
    end
  end

  // Result computation from the value word returned for the latched index.
  always_comb begin
    w_fault = tlb_fault(r_hit, valueData[VALID_BIT], valueData[WRITABLE_BIT], r_write);
    if (w_fault == FAULT_NONE) begin
      w_res_addr = {valueData[FRAME_HI:FRAME_LO], r_offset};
    end else begin
      w_res_addr = 32'h0000_0000;
    end
`ifdef TLB_LOOKUP_UNMAPPED_EN
    if (r_unmapped) begin
      w_fault     = FAULT_NONE;
      w_res_addr  = unmapped_offset({r_vpn, r_offset});
      w_res_index = {INDEX_W{1'b0}};
    end else begin
      w_res_index = r_hit ? r_index : {INDEX_W{1'b0}};
    end
`else
    w_res_index = r_hit ? r_index : {INDEX_W{1'b0}};
`endif
  end

  // Lookup sequencer and registered response.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_req_ready    <= 1'b1;
      r_resp_valid   <= 1'b0;
      r_resp_address <= 32'h0000_0000;
      r_resp_fault   <= FAULT_NONE;
      r_resp_index   <= {INDEX_W{1'b0}};
      r_offset       <= {OFFSET_W{1'b0}};
      r_write        <= 1'b0;
      r_hit          <= 1'b0;
      r_index        <= {INDEX_W{1'b0}};
`ifdef TLB_LOOKUP_UNMAPPED_EN
      r_unmapped     <= 1'b0;
      r_vpn          <= {VPN_W{1'b0}};
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (reqValid) begin
            r_offset    <= reqAddress[OFFSET_W-1:0];
            r_write     <= reqWrite;
            r_hit       <= w_cam_hit;
            r_index     <= w_cam_index;
`ifdef TLB_LOOKUP_UNMAPPED_EN
            r_unmapped  <= (reqAddress[31:30] == 2'b11);
            r_vpn       <= reqAddress[31:OFFSET_W];
`endif
            r_req_ready <= 1'b0;
            r_state     <= ST_READ;
          end
        end
        ST_READ: begin
          r_resp_address <= w_res_addr;
          r_resp_fault   <= w_fault;
          r_resp_index   <= w_res_index;
          r_resp_valid   <= 1'b1;
          r_state        <= ST_RESP;
        end
        ST_RESP: begin
          if (respReady) begin
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= ST_IDLE;
          end
        end
        default: begin
          r_resp_valid <= 1'b0;
          r_req_ready  <= 1'b1;
          r_state      <= ST_IDLE;
        end
      endcase
    end
  end

  assign reqReady    = r_req_ready;
  assign respValid   = r_resp_valid;
  assign respAddress = r_resp_address;
  assign respFault   = r_resp_fault;
  assign respIndex   = r_resp_index;
  assign valueIndex  = w_value_index;

endmodule
